// File: rtl/sw_in_ctrl_if.sv
// rtl/sw_in_ctrl_if.sv - input FIFO, arbiter and crossbar signal bundle for sw_in_ctrl
// master is the controller side, slave is the FIFO/arbiter/crossbar side.
interface sw_in_ctrl_if #(
  parameter int DW = 32
);
  logic [DW-1:0] in_data;
  logic          in_tail;
  logic          in_empty;
  logic          in_pop;
  logic          req0, req1, req2, req3;
  logic          ack0, ack1, ack2, ack3;
  logic          out_full;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_tail;
  logic [1:0]    out_dst;

  modport master (
    input  in_data, in_tail, in_empty, ack0, ack1, ack2, ack3, out_full,
    output in_pop, req0, req1, req2, req3, out_data, out_valid, out_tail, out_dst
  );

  modport slave (
    output in_data, in_tail, in_empty, ack0, ack1, ack2, ack3, out_full,
    input  in_pop, req0, req1, req2, req3, out_data, out_valid, out_tail, out_dst
  );
endinterface

// File: rtl/sw_in_ctrl.sv
// rtl/sw_in_ctrl.sv - per-input-port packet controller for the 4-way switch
// Defining SW_IN_CTRL_STATS_EN adds the pkt_cnt/wait_cnt statistics outputs.
module sw_in_ctrl #(
  parameter int DW      = 32,
  parameter int DST_LSB = 0
) (
  input  logic         clk,
  input  logic         rst,
  sw_in_ctrl_if.master bus
`ifdef SW_IN_CTRL_STATS_EN
  ,
  output logic [15:0]  pkt_cnt,
  output logic [15:0]  wait_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_e;

  state_e        state_q, state_d;
  logic [1:0]    dst_q, dst_d;
  logic [3:0]    req_q, req_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_tail_q, out_tail_d;
  logic [1:0]    out_dst_q, out_dst_d;
  logic [3:0]    ack_vec;
  logic          ack_sel;
  logic          pop;

  assign ack_vec = {bus.ack3, bus.ack2, bus.ack1, bus.ack0};
  assign ack_sel = ack_vec[dst_q];

  // A pending reset wins over a pop so no flit is lost from the FIFO on the reset edge.
  assign pop = (state_q == XFER) && ack_sel && !bus.in_empty && !bus.out_full && !rst;

  always_comb begin
    state_d     = state_q;
    dst_d       = dst_q;
    req_d       = req_q;
    out_data_d  = out_data_q;
    out_tail_d  = out_tail_q;
    out_dst_d   = out_dst_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.in_empty) begin
          dst_d   = bus.in_data[DST_LSB +: 2];
          req_d   = 4'b0001 << bus.in_data[DST_LSB +: 2];
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_sel) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (pop) begin
          out_data_d  = bus.in_data;
          out_tail_d  = bus.in_tail;
          out_dst_d   = dst_q;
          out_valid_d = 1'b1;
          if (bus.in_tail) begin
            req_d   = 4'b0000;
            state_d = REL;
          end
        end
      end
      REL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dst_q       <= 2'd0;
      req_q       <= 4'b0000;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_tail_q  <= 1'b0;
      out_dst_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      dst_q       <= dst_d;
      req_q       <= req_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_tail_q  <= out_tail_d;
      out_dst_q   <= out_dst_d;
    end
  end

  assign bus.in_pop    = pop;
  assign bus.req0      = req_q[0];
  assign bus.req1      = req_q[1];
  assign bus.req2      = req_q[2];
  assign bus.req3      = req_q[3];
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_tail  = out_tail_q;
  assign bus.out_dst   = out_dst_q;

`ifdef SW_IN_CTRL_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  // Both counters wrap naturally at 16 bits.
  assign pkt_cnt_d  = pkt_cnt_q + {15'd0, pop && bus.in_tail};
  assign wait_cnt_d = wait_cnt_q + {15'd0, state_q == REQ};

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q  <= 16'd0;
      wait_cnt_q <= 16'd0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_sw_in_ctrl.sv
// tb/tb_sw_in_ctrl.sv - self-checking bench for sw_in_ctrl
// Directed table, hand sequences and a randomized run against a packet-level model.
module tb_sw_in_ctrl;
  localparam int DW      = 32;
  localparam int DST_LSB = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          tail;
  } flit_t;

  typedef struct {
    logic          empty;
    logic [DW-1:0] data;
    logic          tail;
    logic [3:0]    ack;
    logic          full;
    logic [3:0]    e_req;
    logic          e_pop;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic          e_ot;
    logic [1:0]    e_dst;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sw_in_ctrl_if #(.DW(DW)) bus ();

`ifdef SW_IN_CTRL_STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] wait_cnt;
  sw_in_ctrl #(.DW(DW), .DST_LSB(DST_LSB)) dut (
    .clk(clk), .rst(rst), .bus(bus), .pkt_cnt(pkt_cnt), .wait_cnt(wait_cnt)
  );
`else
  sw_in_ctrl #(.DW(DW), .DST_LSB(DST_LSB)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Packet-level reference state: FIFO contents and the packet currently owning the port.
  flit_t      q[$];
  logic       m_active, m_granted, m_rel;
  logic [1:0] m_dst;
  logic       m_ov, m_ot;
  logic [DW-1:0] m_od;
  logic [1:0] m_odst;
  int         delivered, m_pkts, m_wait;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] req_vec();
    return {bus.req3, bus.req2, bus.req1, bus.req0};
  endfunction

  task automatic set_in(input logic e, input logic [DW-1:0] d, input logic t,
                        input logic [3:0] a, input logic f);
    bus.in_empty = e;
    bus.in_data  = d;
    bus.in_tail  = t;
    {bus.ack3, bus.ack2, bus.ack1, bus.ack0} = a;
    bus.out_full = f;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [3:0] er, input logic ep, input logic eov,
                          input logic [DW-1:0] ed, input logic et, input logic [1:0] edst);
    @(negedge clk);
    chk({tag, "_req"}, req_vec(), er);
    chk({tag, "_pop"}, bus.in_pop, ep);
    chk({tag, "_out_valid"}, bus.out_valid, eov);
    if (eov) begin
      chk({tag, "_out_data"}, bus.out_data, ed);
      chk({tag, "_out_tail"}, bus.out_tail, et);
      chk({tag, "_out_dst"}, bus.out_dst, edst);
    end
    next_cyc();
  endtask

  task automatic model_reset();
    q.delete();
    m_active  = 1'b0;
    m_granted = 1'b0;
    m_rel     = 1'b0;
    m_dst     = 2'd0;
    m_ov      = 1'b0;
    m_ot      = 1'b0;
    m_od      = '0;
    m_odst    = 2'd0;
    delivered = 0;
    m_pkts    = 0;
    m_wait    = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(1'b1, '0, 1'b0, 4'h0, 1'b0);
    next_cyc();
    next_cyc();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic add_pkt(input logic [1:0] dst, input int len);
    flit_t f;
    for (int i = 0; i < len; i++) begin
      f.data = DW'($urandom);
      if (i == 0) f.data[DST_LSB +: 2] = dst;
      f.tail = (i == len - 1);
      q.push_back(f);
    end
  endtask

  // Arbiter answers the request it saw last cycle; in random mode it also drops grants
  // and raises spurious acks on ports it is not granting, and the FIFO/crossbar stall.
  task automatic run_env(input int max_cyc, input bit rnd, input int n_pkts);
    logic [3:0]    ack, req_seen, req_now, prev_nz, mask, e_req;
    logic          empty, full, e_pop, tin;
    logic [DW-1:0] din;
    int            switches;
    int            extra;
    switches = 0;
    extra    = 3;
    req_seen = 4'h0;
    prev_nz  = 4'h0;
    for (int c = 0; c < max_cyc && extra > 0; c++) begin
      for (int i = 0; i < 4; i++) mask[i] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      ack = req_seen & mask;
      if (rnd) ack = ack | (4'($urandom_range(0, 15)) & ~req_seen);
      empty = (q.size() == 0) || (rnd && ($urandom_range(0, 4) == 0));
      full  = rnd && ($urandom_range(0, 2) == 0);
      if (empty) begin
        din = DW'($urandom);
        tin = 1'($urandom);
      end else begin
        din = q[0].data;
        tin = q[0].tail;
      end
      set_in(empty, din, tin, ack, full);
      @(negedge clk);
      e_req   = m_active ? (4'b0001 << m_dst) : 4'b0000;
      e_pop   = m_active && m_granted && ack[m_dst] && !empty && !full;
      req_now = req_vec();
      chk("env_req", req_now, e_req);
      chk("env_pop", bus.in_pop, e_pop);
      chk("env_onehot", $countones(req_now) <= 1, 1);
      chk("env_out_valid", bus.out_valid, m_ov);
      if (m_ov) begin
        chk("env_out_data", bus.out_data, m_od);
        chk("env_out_tail", bus.out_tail, m_ot);
        chk("env_out_dst", bus.out_dst, m_odst);
      end
      if (prev_nz != 4'h0 && req_now != 4'h0 && req_now != prev_nz) switches++;
      prev_nz = req_now;
      m_ov = e_pop;
      if (e_pop) begin
        m_od   = q[0].data;
        m_ot   = q[0].tail;
        m_odst = m_dst;
        if (q[0].tail) begin
          m_active = 1'b0;
          m_rel    = 1'b1;
          delivered++;
          m_pkts++;
        end
        void'(q.pop_front());
      end else if (m_active) begin
        if (!m_granted) begin
          m_wait++;
          if (ack[m_dst]) m_granted = 1'b1;
        end
      end else if (m_rel) begin
        m_rel = 1'b0;
      end else if (!empty) begin
        m_active  = 1'b1;
        m_granted = 1'b0;
        m_dst     = q[0].data[DST_LSB +: 2];
      end
      req_seen = req_now;
      if (delivered == n_pkts) extra--;
      next_cyc();
    end
    chk("env_delivered", delivered, n_pkts);
    chk("env_no_direct_switch", switches, 0);
`ifdef SW_IN_CTRL_STATS_EN
    chk("env_pkt_cnt", pkt_cnt, 16'(m_pkts));
    chk("env_wait_cnt", wait_cnt, 16'(m_wait));
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: simulation bound reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    // 3-flit packet to output 2, ack returned one cycle after the request appears.
    tbl[0] = '{1'b0, 32'h2,  1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0,  1'b0, 2'd0};
    tbl[1] = '{1'b0, 32'h2,  1'b0, 4'h0, 1'b0, 4'h4, 1'b0, 1'b0, 32'h0,  1'b0, 2'd0};
    tbl[2] = '{1'b0, 32'h2,  1'b0, 4'h4, 1'b0, 4'h4, 1'b0, 1'b0, 32'h0,  1'b0, 2'd0};
    tbl[3] = '{1'b0, 32'h2,  1'b0, 4'h4, 1'b0, 4'h4, 1'b1, 1'b0, 32'h0,  1'b0, 2'd0};
    tbl[4] = '{1'b0, 32'h11, 1'b0, 4'h4, 1'b0, 4'h4, 1'b1, 1'b1, 32'h2,  1'b0, 2'd2};
    tbl[5] = '{1'b0, 32'h22, 1'b1, 4'h4, 1'b0, 4'h4, 1'b1, 1'b1, 32'h11, 1'b0, 2'd2};
    tbl[6] = '{1'b1, 32'h0,  1'b0, 4'h4, 1'b0, 4'h0, 1'b0, 1'b1, 32'h22, 1'b1, 2'd2};
    tbl[7] = '{1'b1, 32'h0,  1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0,  1'b0, 2'd0};

    model_reset();
    rst = 1'b1;
    set_in(1'b0, 32'h1, 1'b0, 4'h0, 1'b0);
    next_cyc();
    for (int i = 0; i < 2; i++) step_chk("reset_hold", 4'h0, 1'b0, 1'b0, '0, 1'b0, 2'd0);
    rst = 1'b0;
    step_chk("reset_release", 4'h0, 1'b0, 1'b0, '0, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) step_chk("grant_wait", 4'h2, 1'b0, 1'b0, '0, 1'b0, 2'd0);
`ifdef SW_IN_CTRL_STATS_EN
    chk("grant_wait_cnt", wait_cnt, 16'd5);
`endif
    set_in(1'b0, 32'h1, 1'b0, 4'h2, 1'b0);
    step_chk("grant_arrive", 4'h2, 1'b0, 1'b0, '0, 1'b0, 2'd0);
    step_chk("grant_pop", 4'h2, 1'b1, 1'b0, '0, 1'b0, 2'd0);
    set_in(1'b0, 32'h55, 1'b1, 4'h0, 1'b0);
    step_chk("ack_drop1", 4'h2, 1'b0, 1'b1, 32'h1, 1'b0, 2'd1);
    step_chk("ack_drop2", 4'h2, 1'b0, 1'b0, '0, 1'b0, 2'd0);
    set_in(1'b0, 32'h55, 1'b1, 4'h2, 1'b0);
    step_chk("ack_back", 4'h2, 1'b1, 1'b0, '0, 1'b0, 2'd0);
    set_in(1'b1, 32'h0, 1'b0, 4'h2, 1'b0);
    step_chk("stall_rel", 4'h0, 1'b0, 1'b1, 32'h55, 1'b1, 2'd1);
    set_in(1'b1, 32'h0, 1'b0, 4'h0, 1'b0);
    step_chk("stall_idle", 4'h0, 1'b0, 1'b0, '0, 1'b0, 2'd0);

    foreach (tbl[i]) begin
      set_in(tbl[i].empty, tbl[i].data, tbl[i].tail, tbl[i].ack, tbl[i].full);
      step_chk($sformatf("basic%0d", i), tbl[i].e_req, tbl[i].e_pop, tbl[i].e_ov,
               tbl[i].e_od, tbl[i].e_ot, tbl[i].e_dst);
    end

    set_in(1'b0, 32'h0000AB03, 1'b0, 4'h8, 1'b0);
    step_chk("rstmid_idle", 4'h0, 1'b0, 1'b0, '0, 1'b0, 2'd0);
    step_chk("rstmid_req", 4'h8, 1'b0, 1'b0, '0, 1'b0, 2'd0);
    step_chk("rstmid_pop", 4'h8, 1'b1, 1'b0, '0, 1'b0, 2'd0);
    rst = 1'b1;
    set_in(1'b0, 32'h0000CD00, 1'b0, 4'h8, 1'b0);
    step_chk("rstmid_assert", 4'h8, 1'b0, 1'b1, 32'h0000AB03, 1'b0, 2'd3);
    rst = 1'b0;
    set_in(1'b1, 32'h0, 1'b0, 4'h8, 1'b0);
    step_chk("rstmid_after", 4'h0, 1'b0, 1'b0, '0, 1'b0, 2'd0);
    set_in(1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
    step_chk("rstmid_newhead", 4'h0, 1'b0, 1'b0, '0, 1'b0, 2'd0);
    step_chk("rstmid_newreq", 4'h1, 1'b0, 1'b0, '0, 1'b0, 2'd0);

    do_reset();
    add_pkt(2'd0, 1);
    add_pkt(2'd3, 2);
    run_env(60, 1'b0, 2);

    do_reset();
    for (int i = 0; i < 80; i++) add_pkt(2'($urandom_range(0, 3)), $urandom_range(1, 5));
    run_env(6000, 1'b1, 80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sw_in_ctrl.md
Name: sw_in_ctrl

Overview:
- Per-input-port packet controller for the 4-way switch; one instance sits between each input FIFO and the crossbar.
- Reads the destination field from the head flit and raises a request to that output's round-robin arbiter.
- Holds the request for the whole packet, streams all flits through a registered output stage, then releases the output.
- The four req lines fan out, one to each output arbiter; the four ack lines come back from those arbiters.

Parameters:
- DW, 32, flit data width (bits)
- DST_LSB, 0, bit position of the 2-bit destination field in the head flit (dst = in_data[DST_LSB+1:DST_LSB])

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_data  in  DW  head flit of input FIFO
- in_tail  in  1  head flit is last flit of its packet
- in_empty  in  1  input FIFO empty
- in_pop  out  1  pop input FIFO (combinational)
- req0..req3  out  1 each  request to output arbiter 0..3 (registered)
- ack0..ack3  in  1 each  grant from output arbiter 0..3
- out_full  in  1  crossbar/output buffer cannot accept a flit this cycle
- out_data  out  DW  forwarded flit (registered)
- out_valid  out  1  out_data valid this cycle (registered)
- out_tail  out  1  out_data is tail flit (registered)
- out_dst  out  2  destination of the flit currently in flight (registered)

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high. No other clock or reset.
- Reset: state=IDLE; req0..3=0; out_valid=0; out_tail=0; out_data=0; out_dst=0; in_pop=0. Any packet in flight is abandoned; the request drops on the first edge with rst=1; leftover FIFO flits are the FIFO owner's concern.
- FSM states: IDLE, REQ, XFER, REL.
- IDLE:
  - if !in_empty: latch dst from in_data; set req[dst]=1; go to REQ.
  - req is visible one cycle after the head is presented.
- REQ:
  - hold req[dst]; wait for ack[dst]=1, then go to XFER. No timeout; waits indefinitely.
  - Acks on other indices are ignored.
- XFER:
  - in_pop = ack[dst] & !in_empty & !out_full, asserted only in XFER.
  - On each pop: out_data<=in_data, out_tail<=in_tail, out_valid<=1, out_dst<=dst. Otherwise out_valid<=0 next cycle.
  - Latency: flit popped on edge N appears on out_* during cycle N+1.
  - ack[dst] low during XFER: stall (no pop) and keep req asserted; do not restart arbitration.
  - Pop with in_tail=1: clear req[dst] on the same edge; go to REL.
  - Single-flit packet (head has in_tail=1) is legal: one pop, then REL.
- REL:
  - Exactly one cycle with all req low, so the arbiter sees the release and clears its grant. Then go to IDLE.
  - Minimum gap between packets: REL(1) + IDLE(1) + arbiter grant latency.
- Invariants:
  - At most one req bit high at any time.
  - req never changes index mid-packet.
  - in_pop never high outside XFER.
  - No flit is popped unless ack[dst] is high in that cycle.
- Simultaneous events:
  - out_full and ack both high: no pop.
  - Tail pop while out_full rises: the pop does not occur; wait.

Optional Feature:
- Macro: SW_IN_CTRL_STATS_EN.
- Defined: adds output ports pkt_cnt[15:0] and wait_cnt[15:0].
  - pkt_cnt increments on each tail pop.
  - wait_cnt increments on each cycle spent in REQ.
  - Both wrap from 16'hFFFF to 0, reset to 0 on rst, and are registered.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: hold rst 2 cycles with in_empty=0 -> req0..3=0, out_valid=0, in_pop=0 throughout; after release, req asserted one cycle later.
- Basic transfer:
  - Stimulus: 3-flit packet with dst=2 (data 0x2, 0x11, 0x22; tail on third); ack2 returned 1 cycle after req2.
  - Required: req2 high; 3 pops on consecutive cycles; out_data 0x2, 0x11, 0x22 one cycle after each pop, out_tail on the last; req2 low after the tail pop; 1 REL cycle.
- Grant delay / stall:
  - Hold ack1 low 5 cycles for a dst=1 packet -> no pops; req1 steady; with STATS_EN, wait_cnt=5.
  - Then drop ack1 mid-packet for 2 cycles -> pops pause 2 cycles; req1 stays high.
- Backpressure / empty:
  - Toggle out_full during XFER -> in_pop low whenever out_full=1.
  - Raise in_empty mid-packet -> no pop, out_valid=0, req held.
- Back-to-back packets:
  - Single-flit dst=0 then 2-flit dst=3 -> req0 released, ≥1 cycle with all req low, then req3.
  - Never two req bits high at once; with STATS_EN, pkt_cnt=2.
- Reset mid-packet: assert rst after 1 of 4 flits popped -> req drops on that edge, state IDLE, out_valid=0 next cycle.
